// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Serial UART transmitter for the System_Core telemetry link. A one-cycle
// (or held) transmit strobe captures tx_data, and the byte is shifted out
// LSB-first as start / data / optional parity / stop bits.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   transmit  in   start request, sampled at each rising edge while idle
//   tx_data   in   data word, captured together with an accepted request
//   tx        out  serial line, idle high (registered)
//   busy      out  high from the accepting edge to the end of the last stop bit
//   done      out  one-cycle pulse in the cycle after the last stop bit
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATABITS     = 8,
    parameter int PARITY       = 0,
    parameter int STOPBITS     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transmit,
    input  logic [DATABITS-1:0] tx_data,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int            BW         = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATABITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOPBITS - 1);
    localparam logic          HAS_PARITY = (PARITY != 0);
    localparam logic          ODD_PARITY = (PARITY == 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity bit over the captured word; odd parity is the inverse of even.
    function automatic logic frame_parity(input logic [DATABITS-1:0] d,
                                          input logic                odd);
        return (^d) ^ odd;
    endfunction

    logic [2:0]          state_q, state_d;
    logic [BW-1:0]       baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [DATABITS-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                baud_wrap_s;
    logic [BW-1:0]       baud_next_s;

    // Frame sequencing: the baud counter wraps at the terminal count and every
    // bit/state advance happens on that wrap.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        done_d      = 1'b0;
        baud_wrap_s = (baud_q == BAUD_LAST);
        if (baud_wrap_s) begin
            baud_next_s = {BW{1'b0}};
        end else begin
            baud_next_s = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE: begin
                if (transmit) begin
                    shift_d = tx_data;
                    par_d   = frame_parity(tx_data, ODD_PARITY);
                    bit_d   = 3'd0;
                    baud_d  = {BW{1'b0}};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                baud_d = baud_next_s;
                if (baud_wrap_s) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                baud_d = baud_next_s;
                if (baud_wrap_s) begin
                    shift_d = {1'b0, shift_q[DATABITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 3'd0;
                        state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                baud_d = baud_next_s;
                if (baud_wrap_s) begin
                    bit_d   = 3'd0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                baud_d = baud_next_s;
                if (baud_wrap_s) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = 3'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level is decoded from the next state so that tx is a plain
    // register and changes exactly on bit boundaries.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State, counters and registered outputs; reset drops the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= {DATABITS{1'b0}};
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three instances (no / even / odd parity, 8 data
// bits, 1 stop bit, 4 clocks per bit) driven side by side. A frame-level
// model expands each accepted word into its list of line levels and the
// compare process checks tx/busy/done of every instance on every cycle.
module tb_uart_frame_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] trans = 3'b000;
    logic [7:0] dat [3];
    logic [2:0] tx_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLKS_PER_BIT(C), .DATABITS(8), .PARITY(0), .STOPBITS(1)) u_p0 (
        .clk(clk), .rst(rst), .transmit(trans[0]), .tx_data(dat[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_frame_tx #(.CLKS_PER_BIT(C), .DATABITS(8), .PARITY(1), .STOPBITS(1)) u_p1 (
        .clk(clk), .rst(rst), .transmit(trans[1]), .tx_data(dat[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_frame_tx #(.CLKS_PER_BIT(C), .DATABITS(8), .PARITY(2), .STOPBITS(1)) u_p2 (
        .clk(clk), .rst(rst), .transmit(trans[2]), .tx_data(dat[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    // ---------------- behavioural model ----------------
    // m_pos = cycle index inside the current frame, -1 when idle.
    int   m_pos [3]    = '{-1, -1, -1};
    logic m_done [3]   = '{1'b0, 1'b0, 1'b0};
    logic m_bits [3][12];
    int   m_nbits [3]  = '{10, 11, 11};

    task automatic build(input int j, input logic [7:0] b);
        int n;
        m_bits[j][0] = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[j][1+k] = b[k];
        n = 9;
        if (j != 0) begin
            m_bits[j][9] = (^b) ^ (j == 2);
            n = 10;
        end
        m_bits[j][n] = 1'b1;
        m_nbits[j] = n + 1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 3; j++) begin
                m_pos[j]  = -1;
                m_done[j] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                m_done[j] = 1'b0;
                if (m_pos[j] < 0) begin
                    if (trans[j]) begin
                        build(j, dat[j]);
                        m_pos[j] = 0;
                    end
                end else begin
                    m_pos[j] = m_pos[j] + 1;
                    if (m_pos[j] == m_nbits[j] * C) begin
                        m_pos[j]  = -1;
                        m_done[j] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int j, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%b required=%b", name, j, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            logic etx;
            if (m_pos[j] >= 0) etx = m_bits[j][m_pos[j] / C];
            else               etx = 1'b1;
            check("tx", j, tx_w[j], etx);
            check("busy", j, busy_w[j], (m_pos[j] >= 0));
            check("done", j, done_w[j], m_done[j]);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic rec_tx [3][60];
    logic rec_busy [3][60];
    logic rec_done [3][60];

    // Request the same word on all instances for one cycle; returns at the
    // negedge just after the accepting edge.
    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        trans = 3'b111;
        for (int j = 0; j < 3; j++) dat[j] = b;
        @(negedge clk);
        trans = 3'b000;
    endtask

    task automatic record(input int n);
        for (int c = 0; c < n; c++) begin
            for (int j = 0; j < 3; j++) begin
                rec_tx[j][c]   = tx_w[j];
                rec_busy[j][c] = busy_w[j];
                rec_done[j][c] = done_w[j];
            end
            @(negedge clk);
        end
    endtask

    function automatic int busy_len(input int j);
        int s = 0;
        for (int c = 0; c < 60; c++) if (rec_busy[j][c]) s++;
        return s;
    endfunction

    task automatic check_seq10(input string name, input logic [9:0] seq);
        for (int k = 0; k < 10; k++) check(name, 0, rec_tx[0][4*k+1], seq[k]);
        for (int k = 0; k < 10; k++) check(name, 0, rec_tx[0][4*k+3], seq[k]);
    endtask

    int cnt_busy, cnt_done, cnt_idle;

    initial begin
        for (int j = 0; j < 3; j++) dat[j] = 8'h00;
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);

        // 0xA5 on all three instances.
        pulse(8'hA5);
        record(60);
        check_seq10("seq_a5", 10'b1101001010);
        check_int("busy_len_8n1", busy_len(0), 40);
        check_int("busy_len_even", busy_len(1), 44);
        check_int("busy_len_odd", busy_len(2), 44);
        check("done_8n1", 0, rec_done[0][40], 1'b1);
        check("done_even", 1, rec_done[1][44], 1'b1);
        check("par_even_a5", 1, rec_tx[1][37], 1'b0);
        check("par_odd_a5", 2, rec_tx[2][37], 1'b1);
        check("start_latency", 0, rec_tx[0][0], 1'b0);

        // 0x07: three ones.
        pulse(8'h07);
        record(60);
        check("par_even_07", 1, rec_tx[1][37], 1'b1);
        check("par_odd_07", 2, rec_tx[2][37], 1'b0);
        check("stop_even_07", 1, rec_tx[1][41], 1'b1);

        // Request while busy is ignored.
        pulse(8'h3C);
        cnt_busy = 0;
        for (int c = 0; c < 70; c++) begin
            if (busy_w[0]) cnt_busy++;
            if (c == 9) begin
                trans = 3'b111;
                for (int j = 0; j < 3; j++) dat[j] = 8'hFF;
            end else begin
                trans = 3'b000;
            end
            @(negedge clk);
        end
        check_int("busy_len_ignored_req", cnt_busy, 40);

        // Back-to-back with transmit held high.
        @(negedge clk);
        trans = 3'b111;
        for (int j = 0; j < 3; j++) dat[j] = 8'h55;
        @(negedge clk);
        cnt_done = 0;
        cnt_idle = 0;
        for (int c = 0; c < 123; c++) begin
            if (done_w[0]) cnt_done++;
            if (!busy_w[0] && tx_w[0]) cnt_idle++;
            @(negedge clk);
        end
        trans = 3'b000;
        check_int("b2b_done_count", cnt_done, 3);
        check_int("b2b_idle_cycles", cnt_idle, 3);
        repeat (60) @(negedge clk);

        // Reset during data bit 3.
        pulse(8'hF0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            check("rst_tx", j, tx_w[j], 1'b1);
            check("rst_busy", j, busy_w[j], 1'b0);
            check("rst_done", j, done_w[j], 1'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulse(8'h81);
        record(60);
        check_seq10("seq_81", 10'b1100000010);
        check_int("busy_len_81", busy_len(0), 40);

        // Random requests, random data changes and one reset pulse.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                trans[j] = ($urandom_range(0, 15) == 0);
                dat[j]   = 8'($urandom);
            end
            if (c == 1500) begin
                #3 rst = 1'b0;
            end else if (c == 1503) begin
                rst = 1'b1;
            end
        end
        trans = 3'b000;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
